gate_sweep_ctrl: RTL and testbench

//  Sequencer for the basic gate datapath (and_4_gate, or_gate, and_gate, not_gate,
//  and_4 "clos" term). Drives x/y/w/v through every input combination of the selected gate.

---
 rtl/gate_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Sweeps the selected basic gate through all of its input vectors and records the sampled
// output as a 16-bit truth table. Optional golden-model check: define GATE_SWEEP_CHECK_EN.
module gate_sweep_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  sel,
   input  logic        gate_in,
   output logic        x,
   output logic        y,
   output logic        w,
   output logic        v,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic        mismatch,
   output logic [4:0]  err_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_WAIT,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  sel_q;
   logic [3:0]  idx;
   logic [7:0]  settle_cnt;
   logic [4:0]  vec_cnt;
   logic [3:0]  vec;
   logic        last_idx;

   always_comb begin
      vec_cnt = 5'd0;
      vec     = '0;
      case (sel_q)
         3'd0, 3'd4: begin vec_cnt = 5'd16; vec = idx;                     end
         3'd1, 3'd2: begin vec_cnt = 5'd4;  vec = {idx[1], idx[0], 2'b00}; end
         3'd3:       begin vec_cnt = 5'd2;  vec = {idx[0], 3'b000};        end
         default:    begin vec_cnt = 5'd0;  vec = '0;                      end
      endcase
      last_idx = ({1'b0, idx} == (vec_cnt - 5'd1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = (sel <= 3'd4) ? ST_APPLY : ST_DONE;
         ST_APPLY:  state_nxt = ST_WAIT;
         ST_WAIT:   if (settle_cnt <= 8'd1) state_nxt = ST_SAMPLE;
         ST_SAMPLE: state_nxt = last_idx ? ST_DONE : ST_APPLY;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Outputs are registered from the current state, so they trail the FSM by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= '0;
         idx        <= '0;
         settle_cnt <= '0;
         {x, y, w, v} <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         table_out  <= '0;
      end else begin
         busy <= (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_SAMPLE);
         done <= (state == ST_DONE);
         case (state)
            ST_IDLE: if (start) begin
               sel_q     <= sel;
               idx       <= '0;
               table_out <= '0;
            end
            ST_APPLY: begin
               {x, y, w, v} <= vec;
               settle_cnt   <= SETTLE[7:0];
            end
            ST_WAIT:   settle_cnt <= settle_cnt - 8'd1;
            ST_SAMPLE: begin
               table_out[idx] <= gate_in;
               if (!last_idx) idx <= idx + 4'd1;
            end
            ST_DONE:   {x, y, w, v} <= '0;
            default:   ;
         endcase
      end
   end

`ifdef GATE_SWEEP_CHECK_EN
   logic golden;

   always_comb begin
      golden = 1'b0;
      case (sel_q)
         3'd0:    golden = &idx;
         3'd1:    golden = idx[1] | idx[0];
         3'd2:    golden = idx[1] & idx[0];
         3'd3:    golden = ~idx[0];
         3'd4:    golden = (idx == 4'b1010);
         default: golden = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch <= 1'b0;
         err_cnt  <= '0;
      end else if (state == ST_IDLE && start) begin
         mismatch <= 1'b0;
         err_cnt  <= '0;
      end else if (state == ST_SAMPLE && gate_in != golden) begin
         mismatch <= 1'b1;
         if (err_cnt != 5'd31) err_cnt <= err_cnt + 5'd1;
      end
   end
`else
   assign mismatch = 1'b0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl: gate models on the drive lines, a timeline model of
// every output per cycle, and a few literal expectations for the known truth tables.
module tb_gate_sweep_ctrl;

   localparam int S = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  sel = '0;
   logic        gate_in;
   logic        x, y, w, v, busy, done, mismatch;
   logic [15:0] table_out;
   logic [4:0]  err_cnt;

   gate_sweep_ctrl #(.SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel), .gate_in(gate_in),
      .x(x), .y(y), .w(w), .v(v), .busy(busy), .done(done),
      .table_out(table_out), .mismatch(mismatch), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int vcount(input logic [2:0] sl);
      case (sl)
         3'd0, 3'd4: return 16;
         3'd1, 3'd2: return 4;
         3'd3:       return 2;
         default:    return 0;
      endcase
   endfunction

   // {x,y,w,v} applied for vector k
   function automatic logic [3:0] vec_of(input logic [2:0] sl, input int k);
      logic [3:0] b;
      b = 4'(k);
      case (sl)
         3'd0, 3'd4: return b;
         3'd1, 3'd2: return {b[1], b[0], 2'b00};
         3'd3:       return {b[0], 3'b000};
         default:    return 4'b0000;
      endcase
   endfunction

   function automatic logic gate_fn(input logic [2:0] sl, input logic [3:0] d);
      case (sl)
         3'd0:    return d[3] & d[2] & d[1] & d[0];
         3'd1:    return d[3] | d[2];
         3'd2:    return d[3] & d[2];
         3'd3:    return ~d[3];
         3'd4:    return d[3] & ~d[2] & d[1] & ~d[0];
         default: return 1'b0;
      endcase
   endfunction

   // Sweep model: start edge cycle, length, latched selection and expected results
   bit          have = 0;
   int          cyc = 0;
   int          s = 0;
   int          len = 0;
   int          m_cnt = 0;
   logic [2:0]  m_sel = '0;
   logic [15:0] m_fault = '0;
   bit          m_force = 0;
   logic [15:0] m_tab = '0;
   logic [15:0] m_emask = '0;
   logic [15:0] fault_next = '0;
   bit          force_next = 0;

   always @(posedge clk) begin
      if (rst) begin
         have = 0;
      end else if (start && (!have || cyc >= s + len + 1)) begin
         have    = 1;
         s       = cyc + 1;
         m_sel   = sel;
         m_cnt   = vcount(sel);
         len     = m_cnt * (S + 2);
         m_fault = fault_next;
         m_force = force_next;
         m_tab   = '0;
         m_emask = '0;
         for (int i = 0; i < m_cnt; i++) begin
            m_tab[i]   = m_force ? 1'b1 : (gate_fn(m_sel, vec_of(m_sel, i)) ^ m_fault[i]);
            m_emask[i] = m_tab[i] ^ gate_fn(m_sel, vec_of(m_sel, i));
         end
      end
      cyc = cyc + 1;
   end

   // Gate under sweep, with optional injected faults per vector
   always_comb begin
      logic [3:0] d;
      logic [3:0] di;
      d  = {x, y, w, v};
      di = 4'd0;
      case (m_sel)
         3'd0, 3'd4: di = d;
         3'd1, 3'd2: di = {2'b00, x, y};
         3'd3:       di = {3'b000, x};
         default:    di = 4'd0;
      endcase
      gate_in = m_force ? 1'b1 : (gate_fn(m_sel, d) ^ m_fault[di]);
   end

   always @(negedge clk) begin
      logic        e_busy, e_done;
      logic [3:0]  e_vec;
      logic [15:0] e_tab, msk;
      int          e_err, n;
      e_busy = 0; e_done = 0; e_vec = '0; e_tab = '0; e_err = 0; msk = '0; n = 0;
      if (have) begin
         if (cyc >= s + 1 && cyc <= s + len) begin
            e_busy = 1;
            e_vec  = vec_of(m_sel, (cyc - s - 1) / (S + 2));
         end
         e_done = (cyc == s + len + 1);
         n = (cyc - s) / (S + 2);
         if (n > m_cnt) n = m_cnt;
         for (int i = 0; i < n; i++) msk[i] = 1'b1;
         e_tab = m_tab & msk;
         e_err = $countones(m_emask & msk);
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("xywv", {x, y, w, v}, e_vec);
      chk("table_out", table_out, e_tab);
`ifdef GATE_SWEEP_CHECK_EN
      chk("mismatch", mismatch, e_err > 0);
      chk("err_cnt", err_cnt, e_err);
`else
      chk("mismatch", mismatch, 0);
      chk("err_cnt", err_cnt, 0);
`endif
   end

   task automatic sweep(input logic [2:0] sl, input logic [15:0] fm, input bit frc,
                        input bit disturb, output int lat, output int bcnt);
      bit got;
      @(negedge clk);
      sel = sl; fault_next = fm; force_next = frc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; bcnt = 0; got = 0;
      while (!got && lat < 400) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) bcnt++;
         if (done) got = 1;
         else if (disturb && busy && $urandom_range(3) == 0) begin
            start = 1'b1;
            sel   = 3'($urandom);
         end
      end
      start = 1'b0;
      if (!got) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int lat, bcnt;
      repeat (3) @(negedge clk);
      chk("reset_table", table_out, 16'h0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;

      sweep(3'd0, '0, 0, 0, lat, bcnt);
      chk("and4_lat", lat, 49);
      chk("and4_busy_cycles", bcnt, 48);
      chk("and4_table", table_out, 16'h8000);
      sweep(3'd1, '0, 0, 0, lat, bcnt);
      chk("or2_lat", lat, 13);
      chk("or2_table", table_out, 16'h000E);
      sweep(3'd2, '0, 0, 0, lat, bcnt);
      chk("and2_table", table_out, 16'h0008);
      sweep(3'd3, '0, 0, 0, lat, bcnt);
      chk("not_lat", lat, 7);
      chk("not_table", table_out, 16'h0001);
      sweep(3'd4, '0, 0, 0, lat, bcnt);
      chk("clos_table", table_out, 16'h0400);
      sweep(3'd6, '0, 0, 0, lat, bcnt);
      chk("invalid_lat", lat, 1);
      chk("invalid_table", table_out, 16'h0);
      sweep(3'd0, '0, 0, 1, lat, bcnt);
      chk("disturbed_table", table_out, 16'h8000);
      chk("disturbed_lat", lat, 49);

      // Abort mid-sweep with an asynchronous reset
      @(negedge clk);
      sel = 3'd0; fault_next = '0; force_next = 0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_busy", busy, 0);
      chk("rst_async_xywv", {x, y, w, v}, 0);
      chk("rst_async_done", done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sweep(3'd1, '0, 0, 0, lat, bcnt);
      chk("post_rst_table", table_out, 16'h000E);

`ifdef GATE_SWEEP_CHECK_EN
      sweep(3'd0, '0, 1, 0, lat, bcnt);
      chk("force_table", table_out, 16'hFFFF);
      chk("force_mismatch", mismatch, 1);
      chk("force_err_cnt", err_cnt, 15);
      sweep(3'd0, '0, 0, 0, lat, bcnt);
      chk("clean_mismatch", mismatch, 0);
      chk("clean_err_cnt", err_cnt, 0);
`endif

      for (int r = 0; r < 30; r++) begin
         logic [15:0] fm;
         fm = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom);
         sweep(3'($urandom), fm, $urandom_range(7) == 0, $urandom_range(1) == 1, lat, bcnt);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
